// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: res = x - y, one full-subtractor step per clock, LSB first.
// Optional signed-overflow output ovf is enabled with `define SERIAL_SUBTRACTOR_OVF_EN.
module serial_subtractor #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] res,
   output logic             bout,
   output logic             busy,
   output logic             done
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned CntW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] xs_q, xs_d;
   logic [WIDTH-1:0] ys_q, ys_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             borrow_q, borrow_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             bout_q, bout_d;

   logic bit_a, bit_b, diff, borrow_next, last_step;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
   // Operand sign bits are kept because the working registers shift them out.
   logic xm_q, xm_d;
   logic ym_q, ym_d;
   logic ovf_q, ovf_d;
`endif

   always_comb begin
      bit_a       = xs_q[0];
      bit_b       = ys_q[0];
      diff        = bit_a ^ bit_b ^ borrow_q;
      borrow_next = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & borrow_q);
      last_step   = (cnt_q == CntW'(WIDTH - 1));
   end

   always_comb begin
      state_d  = state_q;
      xs_d     = xs_q;
      ys_d     = ys_q;
      acc_d    = acc_q;
      borrow_d = borrow_q;
      cnt_d    = cnt_q;
      res_d    = res_q;
      bout_d   = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      xm_d     = xm_q;
      ym_d     = ym_q;
      ovf_d    = ovf_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (start) begin
               xs_d     = x;
               ys_d     = y;
               acc_d    = '0;
               borrow_d = 1'b0;
               cnt_d    = '0;
               state_d  = StShift;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
               xm_d     = x[WIDTH-1];
               ym_d     = y[WIDTH-1];
`endif
            end
         end
         StShift: begin
            xs_d     = xs_q >> 1;
            ys_d     = ys_q >> 1;
            acc_d    = {diff, acc_q[WIDTH-1:1]};
            borrow_d = borrow_next;
            cnt_d    = cnt_q + 1'b1;
            if (last_step) begin
               // diff is the result MSB on the final step
               res_d   = {diff, acc_q[WIDTH-1:1]};
               bout_d  = borrow_next;
               state_d = StDone;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
               ovf_d   = (xm_q != ym_q) && (diff != xm_q);
`endif
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         xs_q     <= '0;
         ys_q     <= '0;
         acc_q    <= '0;
         borrow_q <= 1'b0;
         cnt_q    <= '0;
         res_q    <= '0;
         bout_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         xs_q     <= xs_d;
         ys_q     <= ys_d;
         acc_q    <= acc_d;
         borrow_q <= borrow_d;
         cnt_q    <= cnt_d;
         res_q    <= res_d;
         bout_q   <= bout_d;
      end
   end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         xm_q  <= 1'b0;
         ym_q  <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         xm_q  <= xm_d;
         ym_q  <= ym_d;
         ovf_q <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`endif

   assign res  = res_q;
   assign bout = bout_q;
   assign busy = (state_q == StShift);
   assign done = (state_q == StDone);

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: vector table plus reset/abort/ignored-start sequences.
module tb_serial_subtractor;

   localparam int unsigned WIDTH = 8;

   logic             clk;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic [WIDTH-1:0] res;
   logic             bout;
   logic             busy;
   logic             done;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   logic             ovf;
`endif

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .x     (x),
      .y     (y),
      .res   (res),
      .bout  (bout),
      .busy  (busy),
      .done  (done)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH-1:0] x;
      logic [WIDTH-1:0] y;
      logic [WIDTH-1:0] res;
      logic             bout;
      logic             ovf;
      int               inj;   // negedge index after T0 at which a stray start is driven, -1 none
   } vec_t;

   typedef struct {
      logic [WIDTH-1:0] res;
      logic             bout;
      logic             ovf;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      vec_t       v;
      logic [WIDTH:0] d;
      d      = {1'b0, a} - {1'b0, b};
      v.x    = a;
      v.y    = b;
      v.res  = d[WIDTH-1:0];
      v.bout = d[WIDTH];
      v.ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (d[WIDTH-1] != a[WIDTH-1]);
      v.inj  = -1;
      return v;
   endfunction

   task automatic run_op(input vec_t v);
      exp_t             e;
      logic [WIDTH-1:0] prev_res;
      int               busy_cnt = 0;
      int               done_cnt = 0;
      int               done_at  = -1;
      bit               hold_ok  = 1'b1;
      @(negedge clk);
      start = 1'b1;
      x     = v.x;
      y     = v.y;
      sb.push_back('{res: v.res, bout: v.bout, ovf: v.ovf});
      prev_res = res;
      @(posedge clk);
      #1;
      start = 1'b0;
      x     = ~v.x;
      y     = WIDTH'($urandom);
      for (int c = 0; c < int'(WIDTH) + 4; c++) begin
         @(negedge clk);
         if (c == v.inj) begin
            start = 1'b1;
            x     = 8'hAA;
            y     = 8'h55;
         end else if (c == v.inj + 1) begin
            start = 1'b0;
         end
         if (busy) begin
            busy_cnt++;
            if (res !== prev_res) hold_ok = 1'b0;
         end
         if (done) begin
            done_cnt++;
            done_at = c;
            if (done_cnt == 1 && sb.size() > 0) begin
               e = sb.pop_front();
               check("res", 32'(res), 32'(e.res));
               check("bout", 32'(bout), 32'(e.bout));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
               check("ovf", 32'(ovf), 32'(e.ovf));
`endif
            end
         end
      end
      start = 1'b0;
      check("busy_cycles", 32'(busy_cnt), 32'(WIDTH));
      check("done_pulses", 32'(done_cnt), 32'd1);
      check("done_cycle", 32'(done_at), 32'(WIDTH));
      check("res_not_bitwise", 32'(hold_ok), 32'd1);
      check("res_held", 32'(res), 32'(v.res));
      check("bout_held", 32'(bout), 32'(v.bout));
   endtask

   vec_t vecs[$];
   vec_t v;
   int   stray_done;

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      x     = '0;
      y     = '0;
      #3;
      check("rst_res", 32'(res), 32'd0);
      check("rst_bout", 32'(bout), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      vecs.push_back('{x: 8'h05, y: 8'h03, res: 8'h02, bout: 1'b0, ovf: 1'b0, inj: -1});
      vecs.push_back('{x: 8'h03, y: 8'h05, res: 8'hFE, bout: 1'b1, ovf: 1'b0, inj: -1});
      vecs.push_back('{x: 8'hFF, y: 8'h01, res: 8'hFE, bout: 1'b0, ovf: 1'b0, inj: -1});
      vecs.push_back('{x: 8'h00, y: 8'h00, res: 8'h00, bout: 1'b0, ovf: 1'b0, inj: -1});
      vecs.push_back('{x: 8'h10, y: 8'h01, res: 8'h0F, bout: 1'b0, ovf: 1'b0, inj: 2});
      vecs.push_back('{x: 8'h80, y: 8'h01, res: 8'h7F, bout: 1'b0, ovf: 1'b1, inj: -1});
      vecs.push_back('{x: 8'h7F, y: 8'hFF, res: 8'h80, bout: 1'b1, ovf: 1'b1, inj: -1});
      vecs.push_back('{x: 8'h5A, y: 8'h5A, res: 8'h00, bout: 1'b0, ovf: 1'b0, inj: WIDTH});
      vecs.push_back('{x: 8'h00, y: 8'hFF, res: 8'h01, bout: 1'b1, ovf: 1'b0, inj: -1});
      for (int i = 0; i < 6; i++) begin
         vecs.push_back(model(WIDTH'($urandom), WIDTH'($urandom)));
      end
      for (int i = 0; i < vecs.size(); i++) begin
         run_op(vecs[i]);
      end

      // Asynchronous reset between clock edges with a nonzero result held.
      run_op(model(8'h03, 8'h05));
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_res", 32'(res), 32'd0);
      check("async_rst_bout", 32'(bout), 32'd0);
      check("async_rst_busy", 32'(busy), 32'd0);
      check("async_rst_done", 32'(done), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Abort after T4: no done pulse, res stays cleared.
      @(negedge clk);
      start = 1'b1;
      x     = 8'h40;
      y     = 8'h01;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_res", 32'(res), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      stray_done = 0;
      for (int c = 0; c < int'(WIDTH) + 4; c++) begin
         @(negedge clk);
         if (done || busy) stray_done++;
      end
      check("abort_no_done", 32'(stray_done), 32'd0);
      check("abort_res_after", 32'(res), 32'd0);

      v = '{x: 8'h40, y: 8'h01, res: 8'h3F, bout: 1'b0, ovf: 1'b0, inj: -1};
      run_op(v);

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial unsigned subtractor, res = x - y, processed one bit per clock, LSB first.
- Each bit is handled by a full-subtractor cell (difference and borrow), the inverse counterpart of the full-adder cell.
- Start/done handshake with a registered result; used where area is traded for latency next to the adder datapath.

Parameters:
WIDTH, 8, operand and result width in bits (>= 2)

Ports:
clk    input   1       clock, rising-edge active
rst    input   1       asynchronous reset, active-high
start  input   1       request; sampled only in IDLE
x      input   WIDTH   minuend; captured on the accepting edge
y      input   WIDTH   subtrahend; captured on the accepting edge
res    output  WIDTH   registered difference x - y mod 2^WIDTH
bout   output  1       final borrow out (1 when x < y, unsigned)
busy   output  1       high while an operation is in progress
done   output  1       one-cycle pulse when res/bout are updated

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-high (rst).
- Reset (async, any state including mid-operation):
  - state=IDLE; res=0, bout=0, busy=0, done=0.
  - Internal shift registers, borrow flop and bit counter are cleared.
  - Any in-flight operation is discarded, with no done pulse.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at edge T0 loads x and y into working shift registers, clears borrow and counter, and moves to SHIFT.
  - busy=1 from T0.
  - start=0 stays in IDLE.
- SHIFT: on each edge, for a = working x LSB, b = working y LSB, c = borrow:
  - d = a^b^c
  - c_next = (~a & b) | (~(a^b) & c)
  - d is shifted into the MSB of the working result; both operand registers shift right; counter increments.
  - After exactly WIDTH SHIFT edges (edges T1..TWIDTH), the edge TWIDTH:
    - copies the working result into res and the final borrow into bout;
    - sets done=1, busy=0, state=DONE.
- DONE: lasts one cycle; unconditional return to IDLE on the next edge, with done back to 0.
- Latency: done is high in the cycle after edge TWIDTH. The earliest next accepted start is on edge TWIDTH+2.
- start asserted in SHIFT or DONE is ignored: no queueing, no effect on the current operation.
- x and y may change freely after T0 without affecting the result.
- res and bout hold the last completed result until the next completion or reset. They are not updated bit-by-bit.
- Wrap-around: the result is modulo 2^WIDTH, and bout reports the underflow.
- x == y gives res=0, bout=0.

Optional Feature:
Macro: SERIAL_SUBTRACTOR_OVF_EN
- Defined:
  - Adds output port ovf (1 bit), the signed (two's-complement) overflow of x - y.
  - ovf = (x_msb != y_msb) && (res_msb != x_msb), using captured operands.
  - Registered and updated on the same edge as res; reset value 0; held like res.
- Not defined: no ovf port and no related logic; all other behaviour is identical.

Test Plan:
- rst pulse mid-cycle with no clock -> res=0, bout=0, busy=0, done=0 immediately (async).
- WIDTH=8, x=0x05, y=0x03, start for 1 cycle at T0 -> busy high for 8 cycles; after edge T8, done=1 for exactly one cycle with res=0x02, bout=0.
- x=0x03, y=0x05 -> res=0xFE, bout=1. Then x=0xFF, y=0x01 -> res=0xFE, bout=0. Then x=0x00, y=0x00 -> res=0x00, bout=0.
- x=0x10, y=0x01 started; at T3 start=1 with x=0xAA, y=0x55, and operands changed -> second request ignored; res=0x0F, bout=0; single done pulse.
- Operation x=0x40, y=0x01 started; rst asserted after T4 -> immediate IDLE, busy=0, no done pulse, res stays 0. A new start after release gives res=0x3F.
- SERIAL_SUBTRACTOR_OVF_EN: x=0x80, y=0x01 -> res=0x7F, bout=0, ovf=1. x=0x7F, y=0xFF -> res=0x80, bout=1, ovf=1. x=0x05, y=0x03 -> ovf=0.
